host_cmd_parser: RTL and testbench

HOST_CMD_PARSER -- requirements
Module: host_cmd_parser

---
 rtl/host_cmd_parser.sv | 174 +++++++++++++++++
 tb/tb_host_cmd_parser.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_parser.sv
// Host command packet parser: header, payload pass-through through a one-entry register, checksum check.
// Optional inter-word starvation timeout is enabled with macro HOST_CMD_TIMEOUT_EN.
module host_cmd_parser #(
  parameter int host_width     = 16,
  parameter int timeout_cycles = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [host_width-1:0] in_data,
  input  logic                  in_enable,
  output logic                  in_ready,
  output logic [7:0]            hdr_dest,
  output logic [7:0]            hdr_cmd,
  output logic [23:0]           hdr_length,
  output logic                  hdr_valid,
  output logic [host_width-1:0] out_data,
  output logic                  out_enable,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  checksum_error,
  output logic                  timeout_error
);

  typedef enum logic [2:0] {
    S_DEST   = 3'd0,
    S_CMD    = 3'd1,
    S_LEN_HI = 3'd2,
    S_LEN_LO = 3'd3,
    S_DATA   = 3'd4,
    S_CK_HI  = 3'd5,
    S_CK_LO  = 3'd6
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        xfer;
  logic        abort;
  logic [7:0]  dest_tmp;
  logic [7:0]  cmd_tmp;
  logic [7:0]  len_hi_tmp;
  logic [23:0] remaining;
  logic [31:0] csum;
  logic [15:0] ck_hi;

  // Input is held off only while a payload word would overwrite an unaccepted one.
  always_comb begin
    if (state == S_DATA) begin
      in_ready = !out_enable || out_ready;
    end else begin
      in_ready = 1'b1;
    end
  end

  assign xfer = in_enable && in_ready;

  // Next-state logic: one state per transferred word, S_DATA repeats until the count runs out.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_DEST;
    end else if (xfer) begin
      case (state)
        S_DEST:   state_next = S_CMD;
        S_CMD:    state_next = S_LEN_HI;
        S_LEN_HI: state_next = S_LEN_LO;
        S_LEN_LO: state_next = ({len_hi_tmp, in_data} != 24'd0) ? S_DATA : S_CK_HI;
        S_DATA:   state_next = (remaining == 24'd1) ? S_CK_HI : S_DATA;
        S_CK_HI:  state_next = S_CK_LO;
        S_CK_LO:  state_next = S_DEST;
        default:  state_next = S_DEST;
      endcase
    end else begin
      state_next = state;
    end
  end

  // State register, header capture, payload count, running checksum and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_DEST;
      dest_tmp       <= 8'd0;
      cmd_tmp        <= 8'd0;
      len_hi_tmp     <= 8'd0;
      remaining      <= 24'd0;
      csum           <= 32'd0;
      ck_hi          <= 16'd0;
      hdr_dest       <= 8'd0;
      hdr_cmd        <= 8'd0;
      hdr_length     <= 24'd0;
      hdr_valid      <= 1'b0;
      done           <= 1'b0;
      checksum_error <= 1'b0;
    end else begin
      state          <= state_next;
      hdr_valid      <= 1'b0;
      done           <= 1'b0;
      checksum_error <= 1'b0;
      if (xfer) begin
        case (state)
          S_DEST:   dest_tmp   <= in_data[7:0];
          S_CMD:    cmd_tmp    <= in_data[7:0];
          S_LEN_HI: len_hi_tmp <= in_data[7:0];
          S_LEN_LO: begin
            hdr_dest   <= dest_tmp;
            hdr_cmd    <= cmd_tmp;
            hdr_length <= {len_hi_tmp, in_data};
            hdr_valid  <= 1'b1;
            remaining  <= {len_hi_tmp, in_data};
          end
          S_DATA: begin
            remaining <= remaining - 24'd1;
            csum      <= csum + {16'd0, in_data};
          end
          S_CK_HI:  ck_hi <= in_data;
          S_CK_LO: begin
            done           <= 1'b1;
            checksum_error <= ({ck_hi, in_data} != csum);
          end
          default: ;
        endcase
      end
      // The sum restarts whenever the parser heads back to S_DEST.
      if (abort || (xfer && state == S_CK_LO)) begin
        csum <= 32'd0;
      end
    end
  end

  // One-entry payload register; it keeps draining while the parser is past S_DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= 16'd0;
      out_enable <= 1'b0;
    end else if (abort) begin
      out_enable <= 1'b0;
    end else if (xfer && state == S_DATA) begin
      out_data   <= in_data;
      out_enable <= 1'b1;
    end else if (out_ready) begin
      out_enable <= 1'b0;
    end else begin
      out_enable <= out_enable;
    end
  end

`ifdef HOST_CMD_TIMEOUT_EN
  localparam int cnt_w = $clog2(timeout_cycles + 1);
  logic [cnt_w-1:0] idle_cnt;

  // Abort fires on the idle cycle that would bring the count to timeout_cycles.
  assign abort = (state != S_DEST) && !in_enable && (idle_cnt == cnt_w'(timeout_cycles - 1));

  // Starvation counter: only cycles with no word offered count.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt      <= '0;
      timeout_error <= 1'b0;
    end else begin
      timeout_error <= abort;
      if (state == S_DEST || xfer || abort) begin
        idle_cnt <= '0;
      end else if (!in_enable) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= idle_cnt;
      end
    end
  end
`else
  assign abort         = 1'b0;
  assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_host_cmd_parser.sv
// Directed self-checking bench for host_cmd_parser; drives after posedge, samples on negedge.
module tb_host_cmd_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_enable;
  logic        in_ready;
  logic [7:0]  hdr_dest;
  logic [7:0]  hdr_cmd;
  logic [23:0] hdr_length;
  logic        hdr_valid;
  logic [15:0] out_data;
  logic        out_enable;
  logic        out_ready;
  logic        done;
  logic        checksum_error;
  logic        timeout_error;

  logic        ready_cmd;
  logic        toggle_en;
  logic        tog_val;
  int          tcnt;

  int          total;
  int          passed;
  int          failed;

  logic [15:0] rx[$];
  int          hdr_cnt, done_cnt, cerr_cnt, stray_cnt, tmo_cnt, oe_cnt;
  logic [7:0]  hd_dest, hd_cmd;
  logic [23:0] hd_len;

  host_cmd_parser dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_enable(in_enable), .in_ready(in_ready),
    .hdr_dest(hdr_dest), .hdr_cmd(hdr_cmd), .hdr_length(hdr_length), .hdr_valid(hdr_valid),
    .out_data(out_data), .out_enable(out_enable), .out_ready(out_ready), .done(done),
    .checksum_error(checksum_error), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  assign out_ready = toggle_en ? tog_val : ready_cmd;

  // Back-pressure pattern: low for 10 cycles out of every 50.
  always begin
    @(posedge clk);
    #1;
    if (toggle_en) begin
      tcnt    = tcnt + 1;
      tog_val = (tcnt % 50) < 40;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_enable && out_ready) rx.push_back(out_data);
      if (out_enable) oe_cnt++;
      if (hdr_valid) begin
        hdr_cnt++;
        hd_dest = hdr_dest;
        hd_cmd  = hdr_cmd;
        hd_len  = hdr_length;
      end
      if (done) done_cnt++;
      if (checksum_error) begin
        if (done) cerr_cnt++;
        else stray_cnt++;
      end
      if (timeout_error) tmo_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    int k;
    in_data   = w;
    in_enable = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      total++;
      failed++;
      $error("FAIL send_stall observed=in_ready_low expected=accept_within_200");
    end
    @(posedge clk);
    #1;
    in_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    rx.delete();
    hdr_cnt = 0; done_cnt = 0; cerr_cnt = 0; stray_cnt = 0; tmo_cnt = 0; oe_cnt = 0;
  endtask

  task automatic send_pkt_a(input logic [15:0] ck_lo);
    send(16'h0000); send(16'h0020); send(16'h0000); send(16'h0004);
    send(16'h0060); send(16'h0000); send(16'h0000); send(16'h00A9);
    send(16'h0000); send(ck_lo);
  endtask

  task automatic check_pkt_a(input string t, input int exp_err);
    check({t, "_hdr_cnt"}, hdr_cnt, 1);
    check({t, "_dest"}, {24'd0, hd_dest}, 32'h00);
    check({t, "_cmd"}, {24'd0, hd_cmd}, 32'h20);
    check({t, "_len"}, {8'd0, hd_len}, 32'd4);
    check({t, "_rx_n"}, rx.size(), 4);
    if (rx.size() == 4) begin
      check({t, "_rx0"}, {16'd0, rx[0]}, 32'h0060);
      check({t, "_rx1"}, {16'd0, rx[1]}, 32'h0000);
      check({t, "_rx2"}, {16'd0, rx[2]}, 32'h0000);
      check({t, "_rx3"}, {16'd0, rx[3]}, 32'h00A9);
    end
    check({t, "_done"}, done_cnt, 1);
    check({t, "_cerr"}, cerr_cnt, exp_err);
    check({t, "_stray_cerr"}, stray_cnt, 0);
  endtask

  initial begin
    int bad;
    total = 0; passed = 0; failed = 0;
    reset = 1'b1; in_data = 16'h0; in_enable = 1'b0;
    ready_cmd = 1'b1; toggle_en = 1'b0; tog_val = 1'b1; tcnt = 0;
    clear_counts();
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_enable", {31'd0, out_enable}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_hdr", {hdr_dest, hdr_cmd, hdr_length[15:0]}, 32'd0);
    check("rst_pulses", {28'd0, hdr_valid, done, checksum_error, timeout_error}, 32'd0);
    idle(1);

    // Good packet, then the same packet with a corrupt checksum.
    send_pkt_a(16'h0109);
    idle(4);
    check_pkt_a("good", 0);
    check("good_hdr_hold", {24'd0, hdr_cmd}, 32'h20);
    clear_counts();
    send_pkt_a(16'h010A);
    idle(4);
    check_pkt_a("bad_ck", 1);

    // Zero-length broadcast.
    clear_counts();
    send(16'h00FF); send(16'h0021); send(16'h0000); send(16'h0000);
    send(16'h0000); send(16'h0000);
    idle(4);
    check("zl_hdr_cnt", hdr_cnt, 1);
    check("zl_dest", {24'd0, hd_dest}, 32'hFF);
    check("zl_cmd", {24'd0, hd_cmd}, 32'h21);
    check("zl_len", {8'd0, hd_len}, 32'd0);
    check("zl_oe_cycles", oe_cnt, 0);
    check("zl_done", done_cnt, 1);
    check("zl_cerr", cerr_cnt, 0);

    // 512-word packet under periodic back-pressure; sum of 0..511 is 0x0001FF00.
    clear_counts();
    toggle_en = 1'b1;
    send(16'h0001); send(16'h0022); send(16'h0000); send(16'h0200);
    for (int i = 0; i < 512; i++) send(16'(i));
    send(16'h0001); send(16'hFF00);
    idle(30);
    toggle_en = 1'b0;
    idle(2);
    check("big_len", {8'd0, hd_len}, 32'd512);
    check("big_rx_n", rx.size(), 512);
    bad = 0;
    for (int i = 0; i < rx.size() && i < 512; i++) if (rx[i] !== 16'(i)) bad++;
    check("big_order_errs", bad, 0);
    check("big_done", done_cnt, 1);
    check("big_cerr", cerr_cnt, 0);

    // Stall after the length words.
    clear_counts();
    send(16'h0000); send(16'h0030); send(16'h0000); send(16'h0002);
`ifdef HOST_CMD_TIMEOUT_EN
    idle(4200);
    check("tmo_pulse", tmo_cnt, 1);
    check("tmo_no_done", done_cnt, 0);
    clear_counts();
    send_pkt_a(16'h0109);
    idle(4);
    check_pkt_a("after_tmo", 0);
`else
    idle(5000);
    check("stall_no_tmo", tmo_cnt, 0);
    check("stall_no_done", done_cnt, 0);
    send(16'h0001); send(16'h0002); send(16'h0000); send(16'h0003);
    idle(4);
    check("stall_rx_n", rx.size(), 2);
    if (rx.size() == 2) check("stall_rx", {rx[0], rx[1]}, 32'h0001_0002);
    check("stall_done", done_cnt, 1);
    check("stall_cerr", cerr_cnt, 0);
`endif

    // Reset after two of four payload words.
    clear_counts();
    send(16'h0000); send(16'h0040); send(16'h0000); send(16'h0004);
    send(16'h0011); send(16'h0022);
    ready_cmd = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_oe", {31'd0, out_enable}, 32'd0);
    check("mid_rst_hdr_len", {8'd0, hdr_length}, 32'd0);
    idle(1);
    ready_cmd = 1'b1;
    idle(3);
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_rx_n", rx.size(), 1);
    clear_counts();
    send_pkt_a(16'h0109);
    idle(4);
    check_pkt_a("after_rst", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
